// File: rtl/zigzag_reorder.sv
// Ping-pong 8x8 block buffer: accepts 64 coefficients in raster order and
// re-emits them in JPEG zigzag order, one coefficient per cycle on each side.
module zigzag_reorder #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        out_idx,
    output logic              out_last
);

    // Raster address of the coefficient at a given zigzag position.
    function automatic logic [5:0] zz_addr(input logic [5:0] pos);
        logic [5:0] a;
        case (pos)
            6'd0:  a = 6'd0;  6'd1:  a = 6'd1;  6'd2:  a = 6'd8;  6'd3:  a = 6'd16;
            6'd4:  a = 6'd9;  6'd5:  a = 6'd2;  6'd6:  a = 6'd3;  6'd7:  a = 6'd10;
            6'd8:  a = 6'd17; 6'd9:  a = 6'd24; 6'd10: a = 6'd32; 6'd11: a = 6'd25;
            6'd12: a = 6'd18; 6'd13: a = 6'd11; 6'd14: a = 6'd4;  6'd15: a = 6'd5;
            6'd16: a = 6'd12; 6'd17: a = 6'd19; 6'd18: a = 6'd26; 6'd19: a = 6'd33;
            6'd20: a = 6'd40; 6'd21: a = 6'd48; 6'd22: a = 6'd41; 6'd23: a = 6'd34;
            6'd24: a = 6'd27; 6'd25: a = 6'd20; 6'd26: a = 6'd13; 6'd27: a = 6'd6;
            6'd28: a = 6'd7;  6'd29: a = 6'd14; 6'd30: a = 6'd21; 6'd31: a = 6'd28;
            6'd32: a = 6'd35; 6'd33: a = 6'd42; 6'd34: a = 6'd49; 6'd35: a = 6'd56;
            6'd36: a = 6'd57; 6'd37: a = 6'd50; 6'd38: a = 6'd43; 6'd39: a = 6'd36;
            6'd40: a = 6'd29; 6'd41: a = 6'd22; 6'd42: a = 6'd15; 6'd43: a = 6'd23;
            6'd44: a = 6'd30; 6'd45: a = 6'd37; 6'd46: a = 6'd44; 6'd47: a = 6'd51;
            6'd48: a = 6'd58; 6'd49: a = 6'd59; 6'd50: a = 6'd52; 6'd51: a = 6'd45;
            6'd52: a = 6'd38; 6'd53: a = 6'd31; 6'd54: a = 6'd39; 6'd55: a = 6'd46;
            6'd56: a = 6'd53; 6'd57: a = 6'd60; 6'd58: a = 6'd61; 6'd59: a = 6'd54;
            6'd60: a = 6'd47; 6'd61: a = 6'd55; 6'd62: a = 6'd62;
            default: a = 6'd63;
        endcase
        return a;
    endfunction

    logic [DATA_W-1:0] mem [0:1][0:63];

    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [5:0]        wr_idx_q, wr_idx_d;
    logic [5:0]        rd_idx_q, rd_idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [5:0]        out_idx_q, out_idx_d;
    logic              out_last_q, out_last_d;

    logic              wr_en;
    logic              load;
    logic [DATA_W-1:0] rd_data;

    assign in_ready  = ~full_q[wr_bank_q];
    assign wr_en     = in_valid & in_ready;
    assign load      = full_q[rd_bank_q] & (~out_valid_q | out_ready);
    assign rd_data   = mem[rd_bank_q][zz_addr(rd_idx_q)];

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

    // Bank storage; no reset needed since the full flags gate every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank_q][wr_idx_q] <= in_data;
        end
    end

    // Next-state for write/read pointers, full flags and the output register.
    always_comb begin
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;

        if (wr_en) begin
            wr_idx_d = wr_idx_q + 6'd1;
            if (wr_idx_q == 6'd63) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        // Writer only targets a non-full bank and reader only a full one, so
        // a completion and a release in the same cycle always hit different bits.
        if (load) begin
            out_data_d  = rd_data;
            out_idx_d   = rd_idx_q;
            out_last_d  = (rd_idx_q == 6'd63);
            out_valid_d = 1'b1;
            rd_idx_d    = rd_idx_q + 6'd1;
            if (rd_idx_q == 6'd63) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q      <= 2'b00;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_idx_q    <= 6'd0;
            rd_idx_q    <= 6'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= 6'd0;
            out_last_q  <= 1'b0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_zigzag_reorder.sv
// Directed bench for zigzag_reorder: raster blocks in, zigzag order out.
module tb_zigzag_reorder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [5:0] out_idx;
    logic       out_last;

    zigzag_reorder #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int zz [0:63] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
                      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
                      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

    logic [7:0] blk [0:3][0:63];

    // Captured output transfers and stream statistics.
    logic [7:0] obs_d [0:255];
    logic [5:0] obs_i [0:255];
    logic       obs_l [0:255];
    int got, stab_err, ready_low, valid_gap, first_valid, last_in;
    bit timed_out;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Streams blocks blk[first..] in and captures n_out output transfers.
    // Inputs are set on the falling edge; in_ready/out_valid are registered.
    task automatic stream(input int first, input int nblk, input int n_out,
                          input int in_pct, input int rdy_pct, input int budget);
        int sent = 0;
        int cyc = 0;
        int tot = nblk * 64;
        logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
        logic [7:0] pd = 8'd0;
        logic [5:0] pi = 6'd0;
        got = 0; stab_err = 0; ready_low = 0; valid_gap = 0;
        first_valid = -1; last_in = -1; timed_out = 1'b0;
        for (int k = 0; k < 256; k++) begin
            obs_d[k] = 8'hxx; obs_i[k] = 6'hxx; obs_l[k] = 1'bx;
        end
        while (got < n_out && !timed_out) begin
            @(negedge clk);
            cyc++;
            if (pv && !pr && (out_data !== pd || out_idx !== pi || out_last !== pl))
                stab_err++;
            in_valid  = (sent < tot) && ($urandom_range(99) < in_pct);
            in_data   = (sent < tot) ? blk[first + sent / 64][sent % 64] : 8'd0;
            out_ready = ($urandom_range(99) < rdy_pct);
            if (sent < tot && !in_ready) ready_low++;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (got > 0 && !out_valid) valid_gap++;
            if (in_valid && in_ready) begin
                sent++;
                if (sent == tot) last_in = cyc;
            end
            if (out_valid && out_ready) begin
                obs_d[got] = out_data; obs_i[got] = out_idx; obs_l[got] = out_last;
                got++;
            end
            pv = out_valid; pr = out_ready; pd = out_data; pi = out_idx; pl = out_last;
            if (cyc >= budget) timed_out = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'd0 ||
            out_idx !== 6'd0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b ready=%b data=%0d idx=%0d last=%b required 0 1 0 0 0",
                     out_valid, in_ready, out_data, out_idx, out_last);
        end
    endtask

    task automatic test_basic_order();
        for (int i = 0; i < 64; i++) blk[0][i] = 8'(i);
        do_reset();
        stream(0, 1, 64, 100, 100, 300);
        checks++;
        if (timed_out) begin errors++; $display("FAIL t1_timeout: got=%0d required 64", got); end
        // Full flag registers on the 64th accept edge, output loads on the next one.
        checks++;
        if (first_valid !== last_in + 2) begin
            errors++;
            $display("FAIL t1_latency: first_valid=%0d required %0d", first_valid, last_in + 2);
        end
        for (int j = 0; j < 64; j++) begin
            checks++;
            if (obs_d[j] !== 8'(zz[j]) || obs_i[j] !== 6'(j) || obs_l[j] !== 1'(j == 63)) begin
                errors++;
                $display("FAIL t1_out[%0d]: data=%0d idx=%0d last=%b required %0d %0d %b",
                         j, obs_d[j], obs_i[j], obs_l[j], zz[j], j, j == 63);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 64; i++) blk[b][i] = 8'(i * 3 + 50 * b);
        do_reset();
        stream(0, 3, 192, 100, 100, 500);
        checks++;
        if (timed_out || ready_low != 0 || valid_gap != 0) begin
            errors++;
            $display("FAIL t2_flow: timeout=%b ready_low=%0d valid_gap=%0d required 0 0 0",
                     timed_out, ready_low, valid_gap);
        end
        for (int j = 0; j < 192; j++) begin
            checks++;
            if (obs_d[j] !== blk[j / 64][zz[j % 64]] || obs_i[j] !== 6'(j % 64) ||
                obs_l[j] !== 1'(j % 64 == 63)) begin
                errors++;
                $display("FAIL t2_out[%0d]: data=%0d idx=%0d last=%b required %0d %0d %b",
                         j, obs_d[j], obs_i[j], obs_l[j], blk[j / 64][zz[j % 64]], j % 64,
                         j % 64 == 63);
            end
        end
    endtask

    task automatic test_backpressure();
        int low = 0;
        int n = 0;
        bit seen63 = 1'b0;
        logic prev_ir = 1'b1;
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 64; i++) blk[b][i] = 8'(i + 17 * b + 100);
        do_reset();
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = blk[i / 64][i % 64]; out_ready = 1'b0;
            if (!in_ready) low++;
        end
        @(negedge clk);
        in_valid = 1'b1; in_data = blk[2][0];
        checks++;
        if (low != 0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL t3_full: early_low=%0d in_ready=%b required 0 0", low, in_ready);
        end
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 6'd0 || out_data !== blk[0][0] || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL t3_hold: valid=%b idx=%0d data=%0d ready=%b required 1 0 %0d 0",
                     out_valid, out_idx, out_data, in_ready, blk[0][0]);
        end
        // Drain block 0 and watch in_ready release.
        for (int c = 0; c < 200 && n < 64; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (out_valid && out_idx == 6'd63 && !seen63) begin
                seen63 = 1'b1;
                checks++;
                if (in_ready !== 1'b1 || prev_ir !== 1'b0) begin
                    errors++;
                    $display("FAIL t3_release: ready=%b prev=%b required 1 0", in_ready, prev_ir);
                end
            end
            prev_ir = in_ready;
            if (out_valid) begin
                checks++;
                if (out_data !== blk[0][zz[n]] || out_idx !== 6'(n)) begin
                    errors++;
                    $display("FAIL t3_drain[%0d]: data=%0d idx=%0d required %0d %0d",
                             n, out_data, out_idx, blk[0][zz[n]], n);
                end
                n++;
            end
        end
        checks++;
        if (!seen63 || n != 64) begin
            errors++;
            $display("FAIL t3_drain_count: n=%0d seen63=%b required 64 1", n, seen63);
        end
        stream(2, 1, 128, 100, 100, 400);
        for (int j = 0; j < 128; j++) begin
            checks++;
            if (obs_d[j] !== blk[1 + j / 64][zz[j % 64]] || obs_i[j] !== 6'(j % 64)) begin
                errors++;
                $display("FAIL t3_out[%0d]: data=%0d idx=%0d required %0d %0d",
                         j, obs_d[j], obs_i[j], blk[1 + j / 64][zz[j % 64]], j % 64);
            end
        end
    endtask

    task automatic test_random_stall();
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 64; i++) blk[b][i] = 8'((i * 7 + b * 91) ^ 8'h5A);
        do_reset();
        stream(0, 3, 192, 70, 50, 3000);
        checks++;
        if (timed_out || stab_err != 0) begin
            errors++;
            $display("FAIL t4_stable: timeout=%b stab_err=%0d required 0 0", timed_out, stab_err);
        end
        for (int j = 0; j < 192; j++) begin
            checks++;
            if (obs_d[j] !== blk[j / 64][zz[j % 64]] || obs_i[j] !== 6'(j % 64) ||
                obs_l[j] !== 1'(j % 64 == 63)) begin
                errors++;
                $display("FAIL t4_out[%0d]: data=%0d idx=%0d last=%b required %0d %0d %b",
                         j, obs_d[j], obs_i[j], obs_l[j], blk[j / 64][zz[j % 64]], j % 64,
                         j % 64 == 63);
            end
        end
    endtask

    task automatic test_extremes();
        for (int i = 0; i < 64; i++) blk[3][i] = 8'd0;
        blk[3][0]  = 8'h80;
        blk[3][63] = 8'h7F;
        do_reset();
        stream(3, 1, 64, 100, 100, 300);
        checks++;
        if (obs_d[0] !== 8'h80 || obs_d[63] !== 8'h7F || obs_l[63] !== 1'b1) begin
            errors++;
            $display("FAIL t5_ends: first=%h last=%h last_flag=%b required 80 7f 1",
                     obs_d[0], obs_d[63], obs_l[63]);
        end
        for (int j = 1; j < 63; j++) begin
            checks++;
            if (obs_d[j] !== 8'd0) begin
                errors++;
                $display("FAIL t5_zero[%0d]: data=%h required 00", j, obs_d[j]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int stray = 0;
        for (int i = 0; i < 64; i++) begin
            blk[0][i] = 8'(200 - i);
            blk[1][i] = 8'(i ^ 8'hC3);
            blk[2][i] = 8'(i * 5 + 1);
        end
        do_reset();
        for (int i = 0; i < 94; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = blk[i / 64][i % 64]; out_ready = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL t6_pending: valid=%b required 1", out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 6'd0 || out_data !== 8'd0) begin
            errors++;
            $display("FAIL t6_reset: valid=%b ready=%b idx=%0d data=%0d required 0 1 0 0",
                     out_valid, in_ready, out_idx, out_data);
        end
        stream(2, 1, 64, 100, 100, 300);
        for (int j = 0; j < 64; j++) begin
            checks++;
            if (obs_d[j] !== blk[2][zz[j]] || obs_i[j] !== 6'(j)) begin
                errors++;
                $display("FAIL t6_out[%0d]: data=%0d idx=%0d required %0d %0d",
                         j, obs_d[j], obs_i[j], blk[2][zz[j]], j);
            end
        end
        out_ready = 1'b1;
        repeat (70) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        out_ready = 1'b0;
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL t6_residue: stray_valid=%0d required 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_back_to_back();
        test_backpressure();
        test_random_stall();
        test_extremes();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
